// File: rtl/debug_state_uart_dump.sv
// Snapshots CPU debug state on request and streams it as an 8N1 UART frame.
// Optional checksum byte enabled by defining DEBUG_DUMP_CHECKSUM_EN.
module debug_state_uart_dump #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic        main_clk,
    input  logic        main_reset_n,
    input  logic [15:0] debug_user_reg [15:0],
    input  logic [15:0] debug_stack_pointer,
    input  logic [25:0] debug_instruction_fetch_address,
    input  logic        dump_request,
    output logic        uart_tx,
    output logic        busy,
    output logic        dump_done,
    output logic        dump_dropped
);

    // state   | meaning
    // S_IDLE  | line high, waiting for dump_request
    // S_START | start bit (0) of the current byte
    // S_DATA  | 8 data bits, LSB first
    // S_STOP  | stop bit (1); then next byte or end of frame

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [7:0]  SYNC_BYTE = 8'hA5;
`ifdef DEBUG_DUMP_CHECKSUM_EN
    localparam logic [5:0]  LAST_BYTE = 6'd39;
`else
    localparam logic [5:0]  LAST_BYTE = 6'd38;
`endif

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t      state;
    logic [15:0] baud_cnt;
    logic [2:0]  bit_cnt;
    logic [5:0]  byte_idx;
    logic [7:0]  tx_byte;
    logic [7:0]  next_byte;
    logic [15:0] reg_word;
    logic [15:0] snap_reg [16];
    logic [15:0] snap_sp;
    logic [25:0] snap_pc;
`ifdef DEBUG_DUMP_CHECKSUM_EN
    logic [7:0]  csum;
`endif

    wire bit_end = (baud_cnt == BAUD_LAST);

    // Byte that follows the one currently on the line, selected by byte_idx.
    always_comb begin
        next_byte = 8'h00;
        reg_word  = snap_reg[byte_idx[4:1]];
        if (byte_idx < 6'd32) begin
            next_byte = byte_idx[0] ? reg_word[7:0] : reg_word[15:8];
        end else begin
            case (byte_idx)
                6'd32:   next_byte = snap_sp[15:8];
                6'd33:   next_byte = snap_sp[7:0];
                6'd34:   next_byte = {6'b0, snap_pc[25:24]};
                6'd35:   next_byte = snap_pc[23:16];
                6'd36:   next_byte = snap_pc[15:8];
                6'd37:   next_byte = snap_pc[7:0];
`ifdef DEBUG_DUMP_CHECKSUM_EN
                6'd38:   next_byte = csum;
`endif
                default: next_byte = 8'h00;
            endcase
        end
    end

    always_ff @(posedge main_clk or negedge main_reset_n) begin
        if (!main_reset_n) begin
            state        <= S_IDLE;
            baud_cnt     <= 16'd0;
            bit_cnt      <= 3'd0;
            byte_idx     <= 6'd0;
            tx_byte      <= 8'h00;
            snap_sp      <= 16'd0;
            snap_pc      <= 26'd0;
            uart_tx      <= 1'b1;
            busy         <= 1'b0;
            dump_done    <= 1'b0;
            dump_dropped <= 1'b0;
            for (int i = 0; i < 16; i++) snap_reg[i] <= 16'd0;
`ifdef DEBUG_DUMP_CHECKSUM_EN
            csum         <= 8'h00;
`endif
        end else begin
            dump_done    <= 1'b0;
            dump_dropped <= (state != S_IDLE) && dump_request;
            case (state)
                S_IDLE: begin
                    uart_tx <= 1'b1;
                    busy    <= 1'b0;
                    if (dump_request) begin
                        for (int i = 0; i < 16; i++) snap_reg[i] <= debug_user_reg[i];
                        snap_sp  <= debug_stack_pointer;
                        snap_pc  <= debug_instruction_fetch_address;
                        tx_byte  <= SYNC_BYTE;
                        byte_idx <= 6'd0;
                        baud_cnt <= 16'd0;
                        bit_cnt  <= 3'd0;
`ifdef DEBUG_DUMP_CHECKSUM_EN
                        csum     <= 8'h00;
`endif
                        uart_tx  <= 1'b0;
                        busy     <= 1'b1;
                        state    <= S_START;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        baud_cnt <= 16'd0;
                        bit_cnt  <= 3'd0;
                        uart_tx  <= tx_byte[0];
                        state    <= S_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        baud_cnt <= 16'd0;
                        if (bit_cnt == 3'd7) begin
                            uart_tx <= 1'b1;
                            state   <= S_STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            tx_byte <= {1'b1, tx_byte[7:1]};
                            uart_tx <= tx_byte[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                S_STOP: begin
                    if (bit_end) begin
                        baud_cnt <= 16'd0;
                        if (byte_idx == LAST_BYTE) begin
                            busy      <= 1'b0;
                            dump_done <= 1'b1;
                            state     <= S_IDLE;
                        end else begin
                            byte_idx <= byte_idx + 6'd1;
                            tx_byte  <= next_byte;
`ifdef DEBUG_DUMP_CHECKSUM_EN
                            // Checksum covers payload bytes 1..38 only.
                            if (byte_idx <= 6'd37) csum <= csum ^ next_byte;
`endif
                            uart_tx  <= 1'b0;
                            state    <= S_START;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_debug_state_uart_dump.sv
// Directed bench for debug_state_uart_dump: decodes frames at mid-bit and checks timing.
module tb_debug_state_uart_dump;

    localparam int CPB = 4;
`ifdef DEBUG_DUMP_CHECKSUM_EN
    localparam int NB = 40;
`else
    localparam int NB = 39;
`endif
    localparam int FRAME_CYC = NB * 10 * CPB;

    logic        main_clk = 1'b0;
    logic        main_reset_n = 1'b0;
    logic [15:0] user_reg [15:0];
    logic [15:0] sp = 16'd0;
    logic [25:0] pc = 26'd0;
    logic        dump_request = 1'b0;
    logic        uart_tx, busy, dump_done, dump_dropped;

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] exp_bytes [40];

    debug_state_uart_dump #(.CLKS_PER_BIT(CPB)) dut (
        .main_clk                        (main_clk),
        .main_reset_n                    (main_reset_n),
        .debug_user_reg                  (user_reg),
        .debug_stack_pointer             (sp),
        .debug_instruction_fetch_address (pc),
        .dump_request                    (dump_request),
        .uart_tx                         (uart_tx),
        .busy                            (busy),
        .dump_done                       (dump_done),
        .dump_dropped                    (dump_dropped)
    );

    always #5 main_clk = ~main_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic build_expected();
        logic [7:0] x;
        exp_bytes[0] = 8'hA5;
        for (int i = 0; i < 16; i++) begin
            exp_bytes[1 + 2*i] = user_reg[i][15:8];
            exp_bytes[2 + 2*i] = user_reg[i][7:0];
        end
        exp_bytes[33] = sp[15:8];
        exp_bytes[34] = sp[7:0];
        exp_bytes[35] = {6'b0, pc[25:24]};
        exp_bytes[36] = pc[23:16];
        exp_bytes[37] = pc[15:8];
        exp_bytes[38] = pc[7:0];
        x = 8'h00;
        for (int i = 1; i <= 38; i++) x = x ^ exp_bytes[i];
        exp_bytes[39] = x;
    endtask

    task automatic set_basic();
        for (int i = 0; i < 16; i++) user_reg[i] = 16'h0000;
        sp = 16'h1234;
        pc = 26'h0ABCDEF;
        for (int i = 0; i < 40; i++) exp_bytes[i] = 8'h00;
        exp_bytes[0]  = 8'hA5;
        exp_bytes[33] = 8'h12;
        exp_bytes[34] = 8'h34;
        exp_bytes[35] = 8'h00;
        exp_bytes[36] = 8'hAB;
        exp_bytes[37] = 8'hCD;
        exp_bytes[38] = 8'hEF;
        exp_bytes[39] = 8'hAF;
    endtask

    task automatic scramble_inputs();
        for (int i = 0; i < 16; i++) user_reg[i] = ~user_reg[i];
        sp = ~sp;
        pc = ~pc;
    endtask

    // Caller raises dump_request before the edge; that edge is the acceptance edge.
    task automatic run_frame(input string name, input bit hold, input bit scramble, input int drop_at);
        logic       sample [400];
        logic       prev;
        logic [7:0] b;
        int viol, busy_low, done_hi, drops, framing;
        prev = 1'b1; viol = 0; busy_low = 0; done_hi = 0; drops = 0; framing = 0;
        @(posedge main_clk);
        for (int m = 0; m <= FRAME_CYC; m++) begin
            @(negedge main_clk);
            if (m == 0) begin
                check_eq($sformatf("%s_busy_up", name), busy, 1);
                if (!hold) dump_request = 1'b0;
                if (scramble) scramble_inputs();
            end
            if (drop_at >= 0 && m == drop_at) dump_request = 1'b1;
            if (drop_at >= 0 && m == drop_at + 1) dump_request = 1'b0;
            if (dump_dropped === 1'b1) drops++;
            if (m < FRAME_CYC) begin
                if (uart_tx !== prev && (m % CPB) != 0) viol++;
                prev = uart_tx;
                if ((m % CPB) == CPB/2) sample[m / CPB] = uart_tx;
                if (busy !== 1'b1) busy_low++;
                if (dump_done !== 1'b0) done_hi++;
            end else begin
                check_eq($sformatf("%s_done_at_end", name), dump_done, 1);
                check_eq($sformatf("%s_busy_end", name), busy, 0);
            end
        end
        check_eq($sformatf("%s_bit_timing", name), viol, 0);
        check_eq($sformatf("%s_busy_drop_early", name), busy_low, 0);
        check_eq($sformatf("%s_done_early", name), done_hi, 0);
        if (drop_at >= 0) check_eq($sformatf("%s_dropped_pulses", name), drops, 1);
        else if (!hold) check_eq($sformatf("%s_dropped_pulses", name), drops, 0);
        for (int k = 0; k < NB; k++) begin
            if (sample[k*10] !== 1'b0 || sample[k*10 + 9] !== 1'b1) framing++;
            for (int i = 0; i < 8; i++) b[i] = sample[k*10 + 1 + i];
            check_eq($sformatf("%s_byte%0d", name, k), b, exp_bytes[k]);
        end
        check_eq($sformatf("%s_framing", name), framing, 0);
    endtask

    initial begin
        int toggles, activity;
        logic prev_tx;
        for (int i = 0; i < 16; i++) user_reg[i] = 16'h0000;

        // Reset state and quiet idle
        repeat (3) @(negedge main_clk);
        check_eq("rst_uart_tx", uart_tx, 1);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", dump_done, 0);
        check_eq("rst_dropped", dump_dropped, 0);
        main_reset_n = 1'b1;
        toggles = 0; activity = 0; prev_tx = uart_tx;
        repeat (1000) begin
            @(negedge main_clk);
            if (uart_tx !== prev_tx) toggles++;
            prev_tx = uart_tx;
            if (busy !== 1'b0 || dump_done !== 1'b0 || dump_dropped !== 1'b0) activity++;
        end
        check_eq("idle_tx_toggles", toggles, 0);
        check_eq("idle_activity", activity, 0);

        // Basic frame with hand-computed bytes
        set_basic();
        dump_request = 1'b1;
        run_frame("basic", 1'b0, 1'b0, -1);

        // Snapshot isolation: inputs inverted right after acceptance
        for (int i = 0; i < 16; i++) user_reg[i] = 16'hA000 + 16'(i) * 16'h0101;
        sp = 16'hBEEF;
        pc = 26'h3A5C3C1;
        build_expected();
        repeat (2) @(negedge main_clk);
        dump_request = 1'b1;
        run_frame("iso", 1'b0, 1'b1, -1);

        // Overrun: one request pulse mid-frame is dropped, not queued
        build_expected();
        repeat (2) @(negedge main_clk);
        dump_request = 1'b1;
        run_frame("ovr", 1'b0, 1'b0, 100);
        repeat (20) @(negedge main_clk);
        check_eq("ovr_no_second_frame", busy, 0);

        // Held request: back-to-back frames
        build_expected();
        dump_request = 1'b1;
        run_frame("held1", 1'b1, 1'b0, -1);
        run_frame("held2", 1'b0, 1'b0, -1);

        // Mid-frame reset during byte 5 start bit
        repeat (3) @(negedge main_clk);
        set_basic();
        dump_request = 1'b1;
        @(posedge main_clk);
        @(negedge main_clk);
        dump_request = 1'b0;
        repeat (201) @(negedge main_clk);
        check_eq("rst_mid_tx_before", uart_tx, 0);
        #1 main_reset_n = 1'b0;
        #1;
        check_eq("rst_mid_tx_async", uart_tx, 1);
        check_eq("rst_mid_busy", busy, 0);
        repeat (3) @(negedge main_clk);
        main_reset_n = 1'b1;
        activity = 0;
        repeat (50) begin
            @(negedge main_clk);
            if (dump_done !== 1'b0 || uart_tx !== 1'b1 || busy !== 1'b0) activity++;
        end
        check_eq("rst_mid_abandoned", activity, 0);
        dump_request = 1'b1;
        run_frame("post_rst", 1'b0, 1'b0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
